// File: rtl/tinyalu_core_if.sv
// tinyalu_core_if: ALU command handshake signal bundle
interface tinyalu_if;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [2:0]  op;
   logic        start;
   logic        done;
   logic [15:0] result;
   modport master (output A, B, op, start, input done, result);
   modport slave  (input A, B, op, start, output done, result);
endinterface

// File: rtl/tinyalu_core.sv
// tinyalu_core: responder ALU executing add/and/xor in one cycle and mul over MUL_LATENCY edges
module tinyalu_core #(
   parameter int MUL_LATENCY = 3
) (
   input  logic     clk,
   input  logic     reset_n,
   tinyalu_if.slave bus
);
   localparam int CW = $clog2(MUL_LATENCY + 1);
   typedef enum logic [2:0] {IDLE, EXEC, MUL, DONE, WAIT_RELEASE} state_t;
   state_t          st;
   logic [CW-1:0]   cnt;
   logic [7:0]      a_q, b_q;
   logic [2:0]      op_q;
   logic [15:0]     res_next;
   // result of the captured command; anything that is not add/and/xor here must be mul
   always_comb begin
      res_next = op_q == 3'b001 ? 16'(a_q) + 16'(b_q) :
                 op_q == 3'b010 ? {8'h00, a_q & b_q} :
                 op_q == 3'b011 ? {8'h00, a_q ^ b_q} :
                                  16'(a_q) * 16'(b_q);
   end
   // command FSM: capture in IDLE only, registered done pulse and result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st         <= IDLE;
         cnt        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         bus.done   <= 1'b0;
         bus.result <= '0;
      end else begin
         bus.done <= 1'b0;
         case (st)
            IDLE: if (bus.start && bus.op inside {3'b001, 3'b010, 3'b011, 3'b100}) begin
               a_q  <= bus.A;
               b_q  <= bus.B;
               op_q <= bus.op;
               cnt  <= CW'(MUL_LATENCY);
               st   <= bus.op == 3'b100 ? MUL : EXEC;
            end
            EXEC: begin
               bus.result <= res_next;
               bus.done   <= 1'b1;
               st         <= DONE;
            end
            MUL: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  bus.result <= res_next;
                  bus.done   <= 1'b1;
                  st         <= DONE;
               end
            end
            DONE:         st <= bus.start ? WAIT_RELEASE : IDLE;
            WAIT_RELEASE: if (!bus.start) st <= IDLE;
            default:      st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tinyalu_core.sv
// tb_tinyalu_core: directed scoreboard bench for tinyalu_core
module tb_tinyalu_core;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   int   done_count = 0;
   logic [15:0] exp_q[$];
   tinyalu_if bus ();
   tinyalu_core #(.MUL_LATENCY(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   always @(negedge clk) if (bus.done === 1'b1) done_count++;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                      input int lat, input logic [15:0] exp, input int hold, input int chg_a);
      int n;
      int d0;
      logic [15:0] e;
      d0 = done_count;
      n  = 0;
      @(negedge clk);
      bus.A = a;
      bus.B = b;
      bus.op = o;
      bus.start = 1'b1;
      exp_q.push_back(exp);
      do begin
         @(negedge clk);
         n++;
         if (n == 1 && chg_a >= 0) bus.A = 8'(chg_a);
      end while (bus.done !== 1'b1 && n < 20);
      chk({tag, " latency"}, 32'(n), 32'(lat + 1));
      e = 16'hxxxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk({tag, " result"}, 32'(bus.result), 32'(e));
      @(negedge clk);
      chk({tag, " done one cycle"}, 32'(bus.done), 32'(0));
      repeat (hold) @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk({tag, " result held"}, 32'(bus.result), 32'(e));
      chk({tag, " done pulses"}, 32'(done_count - d0), 32'(1));
   endtask
   initial begin
      int d0;
      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.op    = '0;
      repeat (2) @(negedge clk);
      chk("reset done", 32'(bus.done), 32'(0));
      chk("reset result", 32'(bus.result), 32'(0));
      reset_n = 1'b1;
      run("add ff+ff", 8'hFF, 8'hFF, 3'b001, 1, 16'h01FE, 0, -1);
      run("xor", 8'hF0, 8'h3C, 3'b011, 1, 16'h00CC, 0, -1);
      run("and", 8'hF0, 8'h3C, 3'b010, 1, 16'h0030, 0, -1);
      d0 = done_count;
      @(negedge clk);
      bus.A = 8'h55;
      bus.B = 8'h66;
      bus.op = 3'b000;
      bus.start = 1'b1;
      repeat (4) @(negedge clk);
      bus.op = 3'b110;
      repeat (4) @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("noop no done", 32'(done_count - d0), 32'(0));
      chk("noop result kept", 32'(bus.result), 32'(16'h0030));
      run("mul latched", 8'hFF, 8'hFF, 3'b100, 3, 16'hFE01, 0, 1);
      run("add held start", 8'd2, 8'd3, 3'b001, 1, 16'h0005, 3, -1);
      run("xor after release", 8'h0F, 8'hFF, 3'b011, 1, 16'h00F0, 0, -1);
      d0 = done_count;
      @(negedge clk);
      bus.A = 8'h10;
      bus.B = 8'h10;
      bus.op = 3'b100;
      bus.start = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort done", 32'(bus.done), 32'(0));
      chk("abort result", 32'(bus.result), 32'(0));
      bus.start = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort no done", 32'(done_count - d0), 32'(0));
      run("add after reset", 8'd1, 8'd1, 3'b001, 1, 16'h0002, 0, -1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tinyalu_core.md
# tinyalu_core

Responder end of the ALU command handshake: accepts an operand pair and opcode when `start` is raised, executes add/and/xor in one cycle or multiply over a multi-cycle path, and returns a 16-bit `result` with a one-cycle `done` pulse. This is the design under test that the command BFM drives; it sits directly on the `A`/`B`/`op`/`start`/`done`/`result` signal set, with no further bus adaptation.

## Interface
- `MUL_LATENCY`, default 3: number of clock edges from command capture to `done` for multiply. Legal range ≥ 2.
- `clk`  in  1  system clock, rising-edge active.
- `reset_n`  in  1  asynchronous, active-low reset.
- `A`  in  8  operand A, unsigned.
- `B`  in  8  operand B, unsigned.
- `op`  in  3  opcode. Encodings:
  - 000 no_op
  - 001 add
  - 010 and
  - 011 xor
  - 100 mul
  - 101, 110, 111 unused; treated as no_op.
- `start`  in  1  command request. The initiator holds it high, with `A`/`B`/`op` stable, until it sees `done`. For no_op, the initiator drops it after one cycle.
- `done`  out  1  completion pulse. Registered; high for exactly one cycle.
- `result`  out  16  registered result. Valid from the `done` cycle and held until the next completion.

## Operation
- States: IDLE, EXEC, MUL, DONE, WAIT_RELEASE.
- IDLE, at each edge:
  - `start`=1 and op ∈ {add, and, xor}: capture A/B/op, go to EXEC.
  - `start`=1 and op = mul: capture A/B/op, load the latency counter, go to MUL.
  - `start`=1 and op is no_op or unused: ignore. Stay in IDLE, no `done`, `result` unchanged.
- EXEC → DONE on the next edge. That edge writes `result` and sets `done`=1.
- MUL: the counter decrements each edge. At the edge that completes MUL_LATENCY edges from capture, write `result`, set `done`=1, and go to DONE.
- DONE: `done` clears at the next edge.
  - `start`=0 → IDLE.
  - Otherwise → WAIT_RELEASE.
- WAIT_RELEASE → IDLE at the first edge with `start`=0. New commands are accepted only in IDLE, so a `start` held high never triggers a second operation.
- Arithmetic works on the captured operands only. Changes to A/B/op after capture have no effect.
  - add: zero-extended 9-bit sum in `result[8:0]`; `result[15:9]`=0.
  - and, xor: bitwise result in `result[7:0]`; `result[15:8]`=0.
  - mul: full unsigned 16-bit product. No overflow is possible (max 0xFE01).
- Reset (asynchronous, any state):
  - `done`=0, `result`=0x0000, state IDLE, counter 0, captured operands 0.
  - An in-flight operation is discarded and never signals `done`.

## Timing
- T0 is the capture edge.
- Single-cycle ops: `done` rises at edge T0+1 and falls at T0+2. `result` updates at T0+1.
- mul: `done` rises at T0+MUL_LATENCY and falls one edge later.
- Earliest next capture:
  - If `start` is sampled 0 at the edge where `done` falls: the next capture is one edge later.
  - Otherwise: the edge after `start` is first sampled 0.
- `done` and `result` are registered outputs. There is no combinational path from inputs to outputs.
- No back-pressure exists. The initiator must observe `done` within the single pulse cycle.

## Test plan
- **Add, max operands.** A=0xFF, B=0xFF, op=add, `start` held until `done`.
  - `done` is high for exactly one cycle, at T0+1.
  - `result`=0x01FE and stays 0x01FE after `start` drops.
- **And / xor.** A=0xF0, B=0x3C.
  - and → `result`=0x0030.
  - xor → `result`=0x00CC.
  - Each completes with `done` at T0+1.
- **Multiply with operand change.** A=0xFF, B=0xFF, op=mul. Change A to 0x01 at T0+1.
  - `done` at T0+3 (default latency).
  - `result`=0xFE01, proving operands were latched at capture.
- **no_op / unused opcodes.** Preload `result`=0x0030, then hold `start`=1 for 4 cycles with op=000, then with op=110.
  - `done` never asserts.
  - `result` stays 0x0030.
- **Held start after done.** op=add, 2+3. Keep `start` high 3 cycles past `done`.
  - Exactly one `done` pulse; `result`=0x0005.
  - Drop `start`, then issue xor 0x0F^0xFF: `result`=0x00F0.
- **Reset mid-multiply.** Issue mul 0x10×0x10 and pulse `reset_n` low at T0+1 (asynchronous, between edges).
  - `done` and `result` go to 0 immediately.
  - No `done` occurs for the aborted op.
  - After release, add 1+1 → `result`=0x0002 at T0'+1.
